// File: rtl/btn_event_ctrl.sv
// Purpose : turns a debounced button level into short/double/long press pulses
//           and steps a wrapping operating-mode register with them.
// Latency : pulses, mode and busy are registered on the edge that samples the
//           deciding button level. A short press waits out the double-press gap
//           when double-press detection is built in.
// Backpressure: none. The input is a level and the outputs are single-cycle
//           pulses, so there is nothing to stall.
//
// Optional feature: define BTN_EVENT_DOUBLE_EN to build the GAP/PRESS2 states
// and a live double_press output. Without it, a release in PRESS1 fires
// short_press at once, double_press is tied low, and mode never decrements.
//
// Ports:
//   sys_clk      in   system clock
//   rst_n        in   synchronous active-low reset
//   btn          in   debounced button level, already in the sys_clk domain
//   short_press  out  one-cycle pulse for a short press
//   double_press out  one-cycle pulse for a double press
//   long_press   out  one-cycle pulse for a long press
//   mode         out  current mode, 0..NUM_MODES-1
//   busy         out  high while the classifier is not idle
module btn_event_ctrl #(
  parameter int LONG_PRESS_COUNT = 12_000_000,
  parameter int DOUBLE_GAP_COUNT = 3_000_000,
  parameter int NUM_MODES        = 4,
  parameter bit BTN_ACTIVE_LOW   = 1'b0
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         btn,
  output logic                         short_press,
  output logic                         double_press,
  output logic                         long_press,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         busy
);

  // ---------------------------------------------------------------------------
  // Derived sizes and terminal values
  // ---------------------------------------------------------------------------
  localparam int CNT_RANGE = (LONG_PRESS_COUNT > DOUBLE_GAP_COUNT) ?
                             LONG_PRESS_COUNT : DOUBLE_GAP_COUNT;
  localparam int CNT_W     = $clog2(CNT_RANGE);
  localparam int MODE_W    = $clog2(NUM_MODES);

  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LONG_TERM  = CNT_W'(LONG_PRESS_COUNT - 1);
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_ONE   = MODE_W'(1);
`ifdef BTN_EVENT_DOUBLE_EN
  localparam logic [CNT_W-1:0]  GAP_TERM   = CNT_W'(DOUBLE_GAP_COUNT - 1);
`endif

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
`ifdef BTN_EVENT_DOUBLE_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS1 = 2'd1,
    HOLD   = 2'd2
  } state_e;
`endif

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [MODE_W-1:0]  mode_q,  mode_d;
  logic               short_q, short_d;
  logic               long_q,  long_d;
  logic               busy_q,  busy_d;
`ifdef BTN_EVENT_DOUBLE_EN
  logic               double_q, double_d;
`endif

  logic               pressed;
  logic [CNT_W-1:0]   cnt_inc;

  // Normalise polarity once so the FSM only ever reasons about "pressed".
  assign pressed = BTN_ACTIVE_LOW ? ~btn : btn;

  // Saturating increment: the counter must never wrap back into a range that
  // could re-trigger a terminal compare.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_ONE);

  // ---------------------------------------------------------------------------
  // Next-state, counter and pulse decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
`ifdef BTN_EVENT_DOUBLE_EN
    double_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS1;
        end
      end

      PRESS1: begin
        // Release is tested first so a release on the terminal cycle takes
        // the short path instead of firing long_press.
        if (!pressed) begin
`ifdef BTN_EVENT_DOUBLE_EN
          state_d = GAP;
`else
          short_d = 1'b1;
          state_d = IDLE;
`endif
        end else if (cnt_q == LONG_TERM) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end

`ifdef BTN_EVENT_DOUBLE_EN
      GAP: begin
        // A press on the terminal cycle still counts as the second press.
        if (pressed) begin
          state_d = PRESS2;
        end else if (cnt_q == GAP_TERM) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      PRESS2: begin
        // Length of the second press is irrelevant; only its release matters.
        if (!pressed) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
`endif

      HOLD: begin
        // The long press has already been reported; release is silent.
        if (!pressed) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state starts its own count from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode sequencing, updated on the same edge that raises the pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d = mode_q;
    if (long_d) begin
      mode_d = '0;
    end else if (short_d) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : (mode_q + MODE_ONE);
    end
`ifdef BTN_EVENT_DOUBLE_EN
    else if (double_d) begin
      mode_d = (mode_q == '0) ? MODE_LAST : (mode_q - MODE_ONE);
    end
`endif
  end

  // busy is taken from the next state so that, once registered, it always
  // matches the state register without an extra cycle of lag.
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BTN_EVENT_DOUBLE_EN
      double_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      short_q  <= short_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
`ifdef BTN_EVENT_DOUBLE_EN
      double_q <= double_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign mode         = mode_q;
  assign busy         = busy_q;
`ifdef BTN_EVENT_DOUBLE_EN
  assign double_press = double_q;
`else
  assign double_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl with LONG_PRESS_COUNT=20, DOUBLE_GAP_COUNT=10,
// NUM_MODES=3, active-high button. Expected pulses (kind, cycle, mode) are
// queued before stimulus and matched by a monitor as the DUT emits them.
`timescale 1ns/1ps
module tb_btn_event_ctrl;

  localparam int LPC = 20;
  localparam int DGC = 10;
  localparam int NM  = 3;
`ifdef BTN_EVENT_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  // Cycles between the release-sampling edge and the short_press edge.
  localparam int SHORT_DLY = DBL ? DGC : 0;

  localparam int K_SHORT  = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       short_press;
  logic       double_press;
  logic       long_press;
  logic [1:0] mode;
  logic       busy;

  typedef struct {
    int kind;
    int cyc;
    int mode;
  } ev_t;

  ev_t exp_q[$];
  int  cyc        = 0;
  int  n_cmp      = 0;
  int  n_bad      = 0;
  int  model_mode = 0;
  bit  mon_en     = 1'b0;

  btn_event_ctrl #(
    .LONG_PRESS_COUNT (LPC),
    .DOUBLE_GAP_COUNT (DGC),
    .NUM_MODES        (NM),
    .BTN_ACTIVE_LOW   (1'b0)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .mode         (mode),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge counter: at a negedge, cyc is the number of posedges so far.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Queue an expected pulse and advance the reference mode.
  task automatic expect_ev(input int kind, input int c);
    ev_t e;
    if (kind == K_SHORT)       model_mode = (model_mode + 1) % NM;
    else if (kind == K_DOUBLE) model_mode = (model_mode + NM - 1) % NM;
    else                       model_mode = 0;
    e.kind = kind;
    e.cyc  = c;
    e.mode = model_mode;
    exp_q.push_back(e);
  endtask

  task automatic press_for(input int n);
    btn = 1'b1;
    repeat (n) @(negedge sys_clk);
    btn = 1'b0;
  endtask

  // Scoreboard monitor: every observed pulse must match the queue head.
  always @(negedge sys_clk) begin : mon
    int  npulse;
    int  kind;
    ev_t e;
    if (mon_en) begin
      npulse = int'(short_press) + int'(double_press) + int'(long_press);
      if (npulse > 1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_exclusive: %0d pulses high at cycle %0d, required at most 1", npulse, cyc);
      end else if (npulse == 1) begin
        kind = short_press ? K_SHORT : (double_press ? K_DOUBLE : K_LONG);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          if (kind !== e.kind || cyc !== e.cyc) begin
            n_bad++;
            $display("FAIL pulse_event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                     kind, cyc, e.kind, e.cyc);
          end
          n_cmp++;
          if (int'(mode) !== e.mode) begin
            n_bad++;
            $display("FAIL pulse_mode: got mode %0d at cycle %0d, required %0d", mode, cyc, e.mode);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst_n      = 1'b0;
    btn        = 1'b0;
    model_mode = 0;
    @(negedge sys_clk);
    mon_en = 1'b1;
    n_cmp++;
    if ({short_press, double_press, long_press, busy} !== 4'b0000 || mode !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got pulses/busy %b mode %0d, required 0000 mode 0",
               {short_press, double_press, long_press, busy}, mode);
    end
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (50) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_mode: got %0d, required 0", mode);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_double_press;
    int c0;
    c0 = cyc;
    if (DBL) begin
      expect_ev(K_DOUBLE, c0 + 15);
    end else begin
      expect_ev(K_SHORT, c0 + 6);
      expect_ev(K_SHORT, c0 + 15);
    end
    press_for(5);
    repeat (4) @(negedge sys_clk);
    press_for(5);
    repeat (20) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd2) begin
      n_bad++;
      $display("FAIL double_mode: got %0d, required 2", mode);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL double_missing: got %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_long_press;
    int c0;
    c0 = cyc;
    expect_ev(K_LONG, c0 + LPC + 1);
    btn = 1'b1;
    repeat (30) @(negedge sys_clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL long_busy_hold: got %b, required 1", busy);
    end
    btn = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL long_busy_release: got %b, required 0", busy);
    end
    repeat (20) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL long_mode: got %0d, required 0", mode);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL long_missing: got %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap;
    int c0;
    int want;
    for (int i = 0; i < 3; i++) begin
      want = (i + 1) % NM;
      c0 = cyc;
      expect_ev(K_SHORT, c0 + 3 + 1 + SHORT_DLY);
      press_for(3);
      repeat (15) @(negedge sys_clk);
      n_cmp++;
      if (int'(mode) !== want) begin
        n_bad++;
        $display("FAIL wrap_mode_%0d: got %0d, required %0d", i, mode, want);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_missing: got %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_press;
    int c0;
    int t_pulse;
    c0 = cyc;
    t_pulse = c0 + 5 + 1 + SHORT_DLY;
    expect_ev(K_SHORT, t_pulse);
    btn = 1'b1;
    @(negedge sys_clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy_rise: got %b, required 1", busy);
    end
    repeat (4) @(negedge sys_clk);
    btn = 1'b0;
    while (cyc < t_pulse + 1) @(negedge sys_clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy_fall: got %b, required 0", busy);
    end
    repeat (10) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd1) begin
      n_bad++;
      $display("FAIL single_mode: got %0d, required 1", mode);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL single_missing: got %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_boundary;
    int c0;
    // Release sampled on the terminal cycle: short path, no long_press.
    c0 = cyc;
    expect_ev(K_SHORT, c0 + 20 + 1 + SHORT_DLY);
    press_for(20);
    repeat (20) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd2) begin
      n_bad++;
      $display("FAIL boundary_short_mode: got %0d, required 2", mode);
    end
    // One more pressed cycle crosses into a long press.
    c0 = cyc;
    expect_ev(K_LONG, c0 + LPC + 1);
    press_for(21);
    repeat (20) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL boundary_long_mode: got %0d, required 0", mode);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL boundary_missing: got %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mid_reset;
    int c0;
    c0 = cyc;
    expect_ev(K_SHORT, c0 + 3 + 1 + SHORT_DLY);
    press_for(3);
    repeat (15) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd1) begin
      n_bad++;
      $display("FAIL midrst_pre_mode: got %0d, required 1", mode);
    end
    btn = 1'b1;
    repeat (10) @(negedge sys_clk);
    rst_n      = 1'b0;
    model_mode = 0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (busy !== 1'b0 || mode !== 2'd0) begin
      n_bad++;
      $display("FAIL midrst_in_reset: got busy %b mode %0d, required busy 0 mode 0", busy, mode);
    end
    c0 = cyc;
    expect_ev(K_LONG, c0 + LPC + 1);
    rst_n = 1'b1;
    repeat (30) @(negedge sys_clk);
    btn = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_busy_release: got %b, required 0", busy);
    end
    repeat (20) @(negedge sys_clk);
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL midrst_mode: got %0d, required 0", mode);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_missing: got %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    test_reset();
    test_double_press();
    test_long_press();
    test_wrap();
    test_single_press();
    test_boundary();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
